i2c_rbk_arbiter: RTL and testbench
==================================

# i2c_rbk_arbiter

Arbitrates the DCFEB I2C readback buffer between two requesters: the auto-test sequencer, which walks the buffer with clear and increment commands, and the host/JTAG path, which does random-address single reads. The block owns the memory read port (address, read enable) and the auto-test address counter. It issues registered grants under round-robin tie-breaking, and it preempts a host that holds the buffer too long while auto-test is waiting. It sits between the auto-test FSM, the JTAG register block and the readback BRAM.

## Interface
- AW, 4: buffer address width.
- DW, 16: buffer data width.
- RD_LAT, 2: BRAM read latency in cycles, from registered MEM_ADDR/MEM_RE to valid MEM_DOUT; range 1–7.
- HOLD_MAX, 64: maximum number of GNT_H cycles allowed while A_REQ is pending.
- CLK  in  1  clock (CLK).
- RST  in  1  reset (RST), asynchronous, active-high.
- A_REQ  in  1  auto-test requests the buffer.
- A_CLR_ADDR  in  1  auto-test address counter clear.
- A_INCR  in  1  auto-test address counter increment.
- A_GNT  out  1  auto-test owns the buffer.
- H_REQ  in  1  host requests the buffer.
- H_RD  in  1  host single-read strobe.
- H_ADDR  in  AW  host read address.
- H_GNT  out  1  host owns the buffer.
- H_ACK  out  1  one-cycle pulse; H_DATA is valid.
- H_DATA  out  DW  captured host read data.
- MEM_ADDR  out  AW  buffer read address (registered).
- MEM_RE  out  1  buffer read enable (registered).
- MEM_DOUT  in  DW  buffer read data.

## Operation
- States: IDLE, GNT_A, GNT_H, H_WAIT.
- IDLE:
  - A_REQ only → GNT_A.
  - H_REQ only → GNT_H.
  - Both requests → the requester that was not the last owner wins.
  - The `last` bit resets to "host", so auto-test wins the first tie.
- GNT_A:
  - A_GNT=1.
  - MEM_ADDR <= a_addr and MEM_RE <= 1 every cycle.
  - A_REQ=0 → IDLE; last <= A.
  - Auto-test is never preempted.
- GNT_H:
  - H_GNT=1.
  - H_RD=1 → MEM_ADDR <= H_ADDR, MEM_RE <= 1 for one cycle, then → H_WAIT.
  - With no read in progress, MEM_RE=0.
  - H_REQ=0 → IDLE; last <= H.
  - Preemption: hold_cnt counts GNT_H cycles while A_REQ=1 and saturates at HOLD_MAX; it clears on leaving GNT_H. At hold_cnt==HOLD_MAX with no read in progress → IDLE; last <= H. Auto-test then wins the next arbitration even if H_REQ is still high.
- H_WAIT:
  - H_GNT stays 1.
  - Waits RD_LAT cycles, then H_DATA <= MEM_DOUT and H_ACK=1 for one cycle, then → GNT_H.
  - H_RD is ignored in this state.
  - H_REQ dropping here does not abort: the read completes and is acknowledged, and the transition to IDLE happens from GNT_H.
- a_addr counter (AW bits) runs regardless of grant state:
  - A_CLR_ADDR → 0.
  - A_INCR → +1, wrapping from 2^AW−1 to 0.
  - Both asserted → the clear wins.
- Ownership change always passes through one IDLE cycle, so A_GNT and H_GNT are never both 1.
- In IDLE, MEM_RE=0 and MEM_ADDR holds its last value.

## Timing
- Reset values: A_GNT=0, H_GNT=0, H_ACK=0, H_DATA=0, MEM_ADDR=0, MEM_RE=0; state=IDLE, a_addr=0, hold_cnt=0, last=H.
- Grant latency: a request sampled in IDLE at cycle n gives the grant at n+1.
- Release: the grant deasserts the cycle after the request drops.
- Owner switch: release at n, IDLE at n, new grant at n+1.
- Auto-test address path: a_addr change at n → MEM_ADDR at n+1 → data on MEM_DOUT at n+1+RD_LAT.
- Host read: H_RD at n → MEM_ADDR/MEM_RE at n+1 → MEM_DOUT valid at n+1+RD_LAT → H_ACK and H_DATA at n+2+RD_LAT. Total H_RD→H_ACK latency is RD_LAT+2.
- Back-to-back host reads: the next H_RD is accepted the cycle after H_ACK.
- RST asserted mid-read or mid-grant: all outputs return to reset values immediately. There is no H_ACK for the aborted read.

## Test plan
- Tie at reset: A_REQ=H_REQ=1 after RST → A_GNT=1 at cycle 1. Drop A_REQ at cycle 5 → A_GNT=0 at cycle 6 (IDLE), H_GNT=1 at cycle 7.
- Host read (RD_LAT=2, BRAM word 5 = 0xBEEF): H_RD with H_ADDR=5 at n → MEM_RE=1, MEM_ADDR=5 at n+1 → H_ACK=1, H_DATA=0xBEEF at n+4. Only one MEM_RE pulse; a second H_RD during the wait produces no second read.
- Counter: A_CLR_ADDR followed by 17 A_INCR pulses (AW=4) → a_addr=1 (wrapped). A_CLR_ADDR and A_INCR asserted together → a_addr=0.
- Preemption (HOLD_MAX=64): H_GNT held with H_REQ=1 and A_REQ raised at m → H_GNT=0 once hold_cnt reaches 64, A_GNT=1 one cycle later. Repeat with H_RD issued just before the limit → release is delayed until after H_ACK.
- H_REQ dropped during H_WAIT → H_ACK still pulses, then H_GNT=0 the following cycle.
- RST pulsed in H_WAIT → H_GNT=0 and MEM_RE=0 immediately, no H_ACK. After release, a tie again goes to auto-test.

Source files
------------

// File: rtl/i2c_rbk_if.sv
// Signal bundle between the readback arbiter, its two requesters and the readback BRAM read port.
// The master modport is the requester/BRAM side; the slave modport is the arbiter.
interface i2c_rbk_if #(
   parameter int AW = 4,
   parameter int DW = 16
);
   logic          A_REQ;
   logic          A_CLR_ADDR;
   logic          A_INCR;
   logic          A_GNT;
   logic          H_REQ;
   logic          H_RD;
   logic [AW-1:0] H_ADDR;
   logic          H_GNT;
   logic          H_ACK;
   logic [DW-1:0] H_DATA;
   logic [AW-1:0] MEM_ADDR;
   logic          MEM_RE;
   logic [DW-1:0] MEM_DOUT;

   modport master (
      output A_REQ, A_CLR_ADDR, A_INCR, H_REQ, H_RD, H_ADDR, MEM_DOUT,
      input  A_GNT, H_GNT, H_ACK, H_DATA, MEM_ADDR, MEM_RE
   );

   modport slave (
      input  A_REQ, A_CLR_ADDR, A_INCR, H_REQ, H_RD, H_ADDR, MEM_DOUT,
      output A_GNT, H_GNT, H_ACK, H_DATA, MEM_ADDR, MEM_RE
   );
endinterface

// File: rtl/i2c_rbk_arbiter.sv
// Round-robin owner of the DCFEB I2C readback BRAM read port shared by the auto-test sequencer
// and the host/JTAG single-read path; the host is preempted after HOLD_MAX cycles of contention.
module i2c_rbk_arbiter #(
   parameter int AW       = 4,
   parameter int DW       = 16,
   parameter int RD_LAT   = 2,
   parameter int HOLD_MAX = 64
) (
   input logic      CLK,
   input logic      RST,
   i2c_rbk_if.slave bus
);
   localparam int            HW       = $clog2(HOLD_MAX + 1);
   localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_MAX);
   localparam logic [2:0]    WAIT_LIM = 3'(RD_LAT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GNT_A  = 2'd1,
      GNT_H  = 2'd2,
      H_WAIT = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic          last_h_q, last_h_d;
   logic [AW-1:0] a_addr_q, a_addr_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic [2:0]    wait_cnt_q, wait_cnt_d;
   logic          a_gnt_q, a_gnt_d;
   logic          h_gnt_q, h_gnt_d;
   logic          h_ack_q, h_ack_d;
   logic [DW-1:0] h_data_q, h_data_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic          mem_re_q, mem_re_d;

   always_comb begin
      state_d    = state_q;
      last_h_d   = last_h_q;
      wait_cnt_d = wait_cnt_q;
      h_ack_d    = 1'b0;
      h_data_d   = h_data_q;
      mem_addr_d = mem_addr_q;
      mem_re_d   = 1'b0;

      case (state_q)
         IDLE: begin
            // On a tie the requester that did not own the buffer last goes first.
            if (bus.A_REQ && (!bus.H_REQ || last_h_q)) begin
               state_d    = GNT_A;
               mem_addr_d = a_addr_q;
               mem_re_d   = 1'b1;
            end else if (bus.H_REQ) begin
               state_d = GNT_H;
            end else begin
               state_d = IDLE;
            end
         end
         GNT_A: begin
            if (!bus.A_REQ) begin
               state_d  = IDLE;
               last_h_d = 1'b0;
            end else begin
               mem_addr_d = a_addr_q;
               mem_re_d   = 1'b1;
            end
         end
         GNT_H: begin
            if (!bus.H_REQ || (hold_cnt_q == HOLD_LIM)) begin
               state_d  = IDLE;
               last_h_d = 1'b1;
            end else if (bus.H_RD) begin
               state_d    = H_WAIT;
               mem_addr_d = bus.H_ADDR;
               mem_re_d   = 1'b1;
               wait_cnt_d = 3'd0;
            end else begin
               state_d = GNT_H;
            end
         end
         H_WAIT: begin
            if (wait_cnt_q == WAIT_LIM) begin
               state_d  = GNT_H;
               h_data_d = bus.MEM_DOUT;
               h_ack_d  = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 3'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Contention time accumulates across host reads so repeated reads cannot starve auto-test.
      if (state_d == IDLE) begin
         hold_cnt_d = {HW{1'b0}};
      end else if (((state_q == GNT_H) || (state_q == H_WAIT)) && bus.A_REQ && (hold_cnt_q != HOLD_LIM)) begin
         hold_cnt_d = hold_cnt_q + HW'(1);
      end else begin
         hold_cnt_d = hold_cnt_q;
      end

      if (bus.A_CLR_ADDR) begin
         a_addr_d = {AW{1'b0}};
      end else if (bus.A_INCR) begin
         a_addr_d = a_addr_q + AW'(1);
      end else begin
         a_addr_d = a_addr_q;
      end

      a_gnt_d = (state_d == GNT_A);
      h_gnt_d = (state_d == GNT_H) || (state_d == H_WAIT);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= IDLE;
         last_h_q   <= 1'b1;
         a_addr_q   <= {AW{1'b0}};
         hold_cnt_q <= {HW{1'b0}};
         wait_cnt_q <= 3'd0;
         a_gnt_q    <= 1'b0;
         h_gnt_q    <= 1'b0;
         h_ack_q    <= 1'b0;
         h_data_q   <= {DW{1'b0}};
         mem_addr_q <= {AW{1'b0}};
         mem_re_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_h_q   <= last_h_d;
         a_addr_q   <= a_addr_d;
         hold_cnt_q <= hold_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         a_gnt_q    <= a_gnt_d;
         h_gnt_q    <= h_gnt_d;
         h_ack_q    <= h_ack_d;
         h_data_q   <= h_data_d;
         mem_addr_q <= mem_addr_d;
         mem_re_q   <= mem_re_d;
      end
   end

   assign bus.A_GNT    = a_gnt_q;
   assign bus.H_GNT    = h_gnt_q;
   assign bus.H_ACK    = h_ack_q;
   assign bus.H_DATA   = h_data_q;
   assign bus.MEM_ADDR = mem_addr_q;
   assign bus.MEM_RE   = mem_re_q;
endmodule

// File: tb/tb_i2c_rbk_arbiter.sv
// Self-checking bench for i2c_rbk_arbiter: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a timestamp-based ownership model.
module tb_i2c_rbk_arbiter;
   localparam int AW       = 4;
   localparam int DW       = 16;
   localparam int RD_LAT   = 2;
   localparam int HOLD_MAX = 64;

   logic CLK;
   logic RST;
   int   checks;
   int   failures;

   i2c_rbk_if #(.AW(AW), .DW(DW)) bus ();

   i2c_rbk_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .HOLD_MAX(HOLD_MAX)) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // BRAM: contents fixed at start, data appears RD_LAT cycles after the registered address.
   logic [DW-1:0] mem  [1 << AW];
   logic [DW-1:0] pipe [RD_LAT];
   always @(posedge CLK) begin
      pipe[0] <= mem[bus.MEM_ADDR];
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign bus.MEM_DOUT = pipe[RD_LAT-1];

   // Model: owner 0=none 1=auto-test 2=host; reads tracked by the cycle they were accepted.
   int            own, hold, a_addr, cyc, rd_cyc;
   bit            last_h, rd_busy;
   logic [AW-1:0] rd_addr;
   logic          e_agnt, e_hgnt, e_ack, e_mre;
   logic [DW-1:0] e_data;
   logic [AW-1:0] e_maddr;

   task automatic model_reset();
      own = 0; hold = 0; a_addr = 0; last_h = 1'b1; rd_busy = 1'b0;
      e_agnt = 1'b0; e_hgnt = 1'b0; e_ack = 1'b0; e_mre = 1'b0;
      e_data = '0; e_maddr = '0;
   endtask

   task automatic model_step();
      int old;
      old   = own;
      e_ack = 1'b0;
      e_mre = 1'b0;
      if (own == 0) begin
         if (bus.A_REQ && (!bus.H_REQ || last_h)) own = 1;
         else if (bus.H_REQ) own = 2;
      end else if (own == 1) begin
         if (!bus.A_REQ) begin own = 0; last_h = 1'b0; end
      end else if (rd_busy) begin
         if (cyc == rd_cyc + RD_LAT + 1) begin
            e_ack = 1'b1; e_data = mem[rd_addr]; rd_busy = 1'b0;
         end
      end else if (!bus.H_REQ || hold == HOLD_MAX) begin
         own = 0; last_h = 1'b1;
      end else if (bus.H_RD) begin
         rd_busy = 1'b1; rd_cyc = cyc; rd_addr = bus.H_ADDR;
         e_maddr = bus.H_ADDR; e_mre = 1'b1;
      end
      if (own == 1) begin e_maddr = AW'(a_addr); e_mre = 1'b1; end
      if (own == 0) hold = 0;
      else if (old == 2 && bus.A_REQ && hold < HOLD_MAX) hold = hold + 1;
      if (bus.A_CLR_ADDR) a_addr = 0;
      else if (bus.A_INCR) a_addr = (a_addr + 1) % (1 << AW);
      e_agnt = (own == 1);
      e_hgnt = (own == 2);
      cyc = cyc + 1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic compare();
      chk("A_GNT",    32'(bus.A_GNT),    32'(e_agnt));
      chk("H_GNT",    32'(bus.H_GNT),    32'(e_hgnt));
      chk("H_ACK",    32'(bus.H_ACK),    32'(e_ack));
      chk("H_DATA",   32'(bus.H_DATA),   32'(e_data));
      chk("MEM_RE",   32'(bus.MEM_RE),   32'(e_mre));
      chk("MEM_ADDR", 32'(bus.MEM_ADDR), 32'(e_maddr));
   endtask

   task automatic cyc_step();
      @(posedge CLK);
      if (RST) model_reset();
      else model_step();
      #1;
      compare();
   endtask

   initial begin
      int j;
      int ack_at;
      int re_cnt;
      checks = 0; failures = 0; cyc = 0; rd_cyc = 0; rd_addr = '0;
      RST = 1'b1;
      bus.A_REQ = 1'b0; bus.A_CLR_ADDR = 1'b0; bus.A_INCR = 1'b0;
      bus.H_REQ = 1'b0; bus.H_RD = 1'b0; bus.H_ADDR = '0;
      for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
      mem[5] = 16'hBEEF;
      model_reset();
      repeat (3) cyc_step();
      RST = 1'b0;
      cyc_step();
      chk("reset_a_gnt", 32'(bus.A_GNT), 32'd0);
      chk("reset_h_gnt", 32'(bus.H_GNT), 32'd0);
      chk("reset_h_data", 32'(bus.H_DATA), 32'd0);
      chk("reset_mem_re", 32'(bus.MEM_RE), 32'd0);

      // Tie right after reset goes to auto-test; host follows through one IDLE cycle.
      bus.A_REQ = 1'b1; bus.H_REQ = 1'b1;
      cyc_step();
      chk("tie_a_gnt", 32'(bus.A_GNT), 32'd1);
      chk("tie_h_gnt", 32'(bus.H_GNT), 32'd0);
      repeat (4) cyc_step();
      bus.A_REQ = 1'b0;
      cyc_step();
      chk("release_a_gnt", 32'(bus.A_GNT), 32'd0);
      chk("release_idle_h_gnt", 32'(bus.H_GNT), 32'd0);
      cyc_step();
      chk("switch_h_gnt", 32'(bus.H_GNT), 32'd1);

      // Host read of word 5 with a second, ignored H_RD during the wait.
      bus.H_RD = 1'b1; bus.H_ADDR = 4'd5;
      cyc_step();
      chk("rd_mem_re", 32'(bus.MEM_RE), 32'd1);
      chk("rd_mem_addr", 32'(bus.MEM_ADDR), 32'd5);
      re_cnt = 1;
      bus.H_RD = 1'b0;
      cyc_step();
      re_cnt = re_cnt + int'(bus.MEM_RE);
      bus.H_RD = 1'b1; bus.H_ADDR = 4'd3;
      cyc_step();
      re_cnt = re_cnt + int'(bus.MEM_RE);
      bus.H_RD = 1'b0;
      chk("rd_no_early_ack", 32'(bus.H_ACK), 32'd0);
      cyc_step();
      re_cnt = re_cnt + int'(bus.MEM_RE);
      chk("rd_ack", 32'(bus.H_ACK), 32'd1);
      chk("rd_data", 32'(bus.H_DATA), 32'hBEEF);
      chk("rd_single_re", 32'(re_cnt), 32'd1);
      cyc_step();
      chk("rd_ack_one_cycle", 32'(bus.H_ACK), 32'd0);

      // Preemption of an idle host after HOLD_MAX contended cycles.
      bus.A_REQ = 1'b1;
      j = 0;
      while (j < 100 && bus.H_GNT) begin cyc_step(); j = j + 1; end
      chk("preempt_release_cycle", 32'(j), 32'd65);
      cyc_step();
      chk("preempt_a_gnt", 32'(bus.A_GNT), 32'd1);
      bus.A_REQ = 1'b0;
      cyc_step(); cyc_step();
      chk("regrant_h_gnt", 32'(bus.H_GNT), 32'd1);

      // Preemption with a read started just before the limit.
      bus.A_REQ = 1'b1;
      repeat (62) cyc_step();
      bus.H_RD = 1'b1; bus.H_ADDR = 4'd7;
      cyc_step();
      bus.H_RD = 1'b0;
      j = 63; ack_at = 0;
      while (j < 150 && bus.H_GNT) begin
         cyc_step(); j = j + 1;
         if (bus.H_ACK) ack_at = j;
      end
      chk("preempt_rd_ack_cycle", 32'(ack_at), 32'd66);
      chk("preempt_rd_release_cycle", 32'(j), 32'd67);
      chk("preempt_rd_data", 32'(bus.H_DATA), 32'(mem[7]));
      cyc_step();
      chk("preempt_rd_a_gnt", 32'(bus.A_GNT), 32'd1);

      // Address counter: clear then 17 increments wraps to 1; clear beats increment.
      bus.A_CLR_ADDR = 1'b1;
      cyc_step();
      bus.A_CLR_ADDR = 1'b0; bus.A_INCR = 1'b1;
      repeat (17) cyc_step();
      bus.A_INCR = 1'b0;
      cyc_step(); cyc_step();
      chk("cnt_wrap_addr", 32'(bus.MEM_ADDR), 32'd1);
      bus.A_CLR_ADDR = 1'b1; bus.A_INCR = 1'b1;
      cyc_step();
      bus.A_CLR_ADDR = 1'b0; bus.A_INCR = 1'b0;
      cyc_step(); cyc_step();
      chk("cnt_clr_wins_addr", 32'(bus.MEM_ADDR), 32'd0);

      // H_REQ dropped while a read is outstanding.
      bus.A_REQ = 1'b0;
      cyc_step(); cyc_step();
      chk("drop_setup_h_gnt", 32'(bus.H_GNT), 32'd1);
      bus.H_RD = 1'b1; bus.H_ADDR = 4'd5;
      cyc_step();
      bus.H_RD = 1'b0; bus.H_REQ = 1'b0;
      repeat (3) cyc_step();
      chk("drop_ack", 32'(bus.H_ACK), 32'd1);
      chk("drop_h_gnt_held", 32'(bus.H_GNT), 32'd1);
      cyc_step();
      chk("drop_h_gnt_off", 32'(bus.H_GNT), 32'd0);

      // Reset in the middle of a host read.
      bus.H_REQ = 1'b1;
      cyc_step(); cyc_step();
      bus.H_RD = 1'b1; bus.H_ADDR = 4'd2;
      cyc_step();
      bus.H_RD = 1'b0;
      RST = 1'b1;
      #1;
      chk("rst_h_gnt", 32'(bus.H_GNT), 32'd0);
      chk("rst_mem_re", 32'(bus.MEM_RE), 32'd0);
      chk("rst_h_data", 32'(bus.H_DATA), 32'd0);
      model_reset();
      re_cnt = 0;
      repeat (2) begin cyc_step(); re_cnt = re_cnt + int'(bus.H_ACK); end
      RST = 1'b0; bus.A_REQ = 1'b1; bus.H_REQ = 1'b1;
      cyc_step();
      re_cnt = re_cnt + int'(bus.H_ACK);
      chk("rst_tie_a_gnt", 32'(bus.A_GNT), 32'd1);
      chk("rst_tie_h_gnt", 32'(bus.H_GNT), 32'd0);
      repeat (4) begin cyc_step(); re_cnt = re_cnt + int'(bus.H_ACK); end
      chk("rst_no_ack", 32'(re_cnt), 32'd0);

      // Randomized traffic; slow request toggling lets preemption occur naturally.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 29) == 0) bus.A_REQ = ~bus.A_REQ;
         if ($urandom_range(0, 89) == 0) bus.H_REQ = ~bus.H_REQ;
         bus.H_RD       = ($urandom_range(0, 3) == 0);
         bus.H_ADDR     = AW'($urandom);
         bus.A_CLR_ADDR = ($urandom_range(0, 15) == 0);
         bus.A_INCR     = ($urandom_range(0, 2) == 0);
         cyc_step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
